// File: rtl/mem_read_arbiter.sv
// Two-requester round-robin arbiter sharing one 4-phase memory read port.
// Requesters use dual-rail commands; rq and mem_ack are synchronized into clk.
module mem_read_arbiter #(
    parameter int AW = 16,
    parameter int DW = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [1:0]    rq0,
    input  logic [AW-1:0] addr0,
    output logic          ack0,
    output logic [DW-1:0] rdata0,
    input  logic [1:0]    rq1,
    input  logic [AW-1:0] addr1,
    output logic          ack1,
    output logic [DW-1:0] rdata1,
    output logic          mem_req,
    output logic [AW-1:0] mem_addr,
    input  logic          mem_ack,
    input  logic [DW-1:0] mem_rdata,
    output logic          err
);

    typedef enum logic [1:0] {
        RQ_NULL = 2'b00,
        RQ_NOP  = 2'b01,
        RQ_READ = 2'b10,
        RQ_ILL  = 2'b11
    } rq_code_t;

    typedef enum logic [1:0] {
        IDLE,
        MREQ,
        MREL,
        ACK
    } state_t;

    state_t        state;
    logic          g;
    logic          last;

    logic [1:0]    rq0_m, rq0_s;
    logic [1:0]    rq1_m, rq1_s;
    logic          mem_ack_m, mem_ack_s;

    logic          pend0, pend1, any_pend, illegal;
    logic          pick_g;
    logic [1:0]    pick_cmd;
    logic [AW-1:0] pick_addr;
    logic [1:0]    rq_g_s;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rq0_m     <= '0;
            rq0_s     <= '0;
            rq1_m     <= '0;
            rq1_s     <= '0;
            mem_ack_m <= 1'b0;
            mem_ack_s <= 1'b0;
        end else begin
            rq0_m     <= rq0;
            rq0_s     <= rq0_m;
            rq1_m     <= rq1;
            rq1_s     <= rq1_m;
            mem_ack_m <= mem_ack;
            mem_ack_s <= mem_ack_m;
        end
    end

    // Illegal 11 codes are excluded from pending; only READ and NOP compete.
    always_comb begin
        pend0     = (rq0_s == RQ_READ) || (rq0_s == RQ_NOP);
        pend1     = (rq1_s == RQ_READ) || (rq1_s == RQ_NOP);
        any_pend  = pend0 || pend1;
        illegal   = (rq0_s == RQ_ILL) || (rq1_s == RQ_ILL);
        pick_g    = (pend0 && pend1) ? ~last : pend1;
        pick_cmd  = pick_g ? rq1_s : rq0_s;
        pick_addr = pick_g ? addr1 : addr0;
        rq_g_s    = g ? rq1_s : rq0_s;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            g        <= 1'b0;
            last     <= 1'b1;
            mem_req  <= 1'b0;
            mem_addr <= '0;
            ack0     <= 1'b0;
            ack1     <= 1'b0;
            rdata0   <= '0;
            rdata1   <= '0;
            err      <= 1'b0;
        end else begin
            if (illegal)
                err <= 1'b1;
            case (state)
                IDLE: begin
                    if (any_pend) begin
                        if (pick_cmd == RQ_NOP) begin
                            g     <= pick_g;
                            ack0  <= !pick_g;
                            ack1  <= pick_g;
                            state <= ACK;
                        // A READ waits here until the memory has released its previous ack.
                        end else if (!mem_ack_s) begin
                            g        <= pick_g;
                            mem_addr <= pick_addr;
                            mem_req  <= 1'b1;
                            state    <= MREQ;
                        end
                    end
                end
                MREQ: begin
                    if (mem_ack_s) begin
                        if (g)
                            rdata1 <= mem_rdata;
                        else
                            rdata0 <= mem_rdata;
                        mem_req <= 1'b0;
                        state   <= MREL;
                    end
                end
                MREL: begin
                    if (!mem_ack_s) begin
                        ack0  <= !g;
                        ack1  <= g;
                        state <= ACK;
                    end
                end
                ACK: begin
                    if (rq_g_s == RQ_NULL) begin
                        ack0  <= 1'b0;
                        ack1  <= 1'b0;
                        last  <= g;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_read_arbiter.sv
// Randomized bench for mem_read_arbiter with a reactive memory responder and
// a transaction-level model of round-robin order, read data and the err flag.
module tb_mem_read_arbiter;

    localparam logic [1:0] C_NULL = 2'b00;
    localparam logic [1:0] C_NOP  = 2'b01;
    localparam logic [1:0] C_READ = 2'b10;
    localparam logic [1:0] C_ILL  = 2'b11;

    logic        clk;
    logic        rst_n;
    logic [1:0]  rq0, rq1;
    logic [15:0] addr0, addr1;
    logic        ack0, ack1;
    logic [15:0] rdata0, rdata1;
    logic        mem_req;
    logic [15:0] mem_addr;
    logic        mem_ack;
    logic [15:0] mem_rdata;
    logic        err;

    int n_cmp;
    int n_fail;

    // memory responder controls and address log
    logic        mem_auto;
    logic        mem_force_ack;
    logic [15:0] log_addr [0:255];
    int          log_wr;
    int          log_rd;

    // monitor counters
    int mon_viol;
    int mem_rises;

    // reference model state
    logic [15:0] exp_rdata [2];
    int          last_served;
    logic        exp_err;

    mem_read_arbiter #(.AW(16), .DW(16)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .rq0      (rq0),
        .addr0    (addr0),
        .ack0     (ack0),
        .rdata0   (rdata0),
        .rq1      (rq1),
        .addr1    (addr1),
        .ack1     (ack1),
        .rdata1   (rdata1),
        .mem_req  (mem_req),
        .mem_addr (mem_addr),
        .mem_ack  (mem_ack),
        .mem_rdata(mem_rdata),
        .err      (err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [15:0] memval(input logic [15:0] a);
        logic [31:0] t;
        t = {16'h0, a} * 32'h9E37;
        return (a == 16'h1234) ? 16'hBEEF : (t[15:0] ^ 16'h5A5A);
    endfunction

    initial begin
        mem_ack   = 1'b0;
        mem_rdata = 16'h0;
        log_wr    = 0;
        forever begin
            @(posedge clk);
            #1;
            if (!mem_auto) begin
                mem_ack = mem_force_ack;
            end else if (mem_req && !mem_ack) begin
                repeat ($urandom_range(0, 3)) @(posedge clk);
                #1;
                mem_rdata = memval(mem_addr);
                log_addr[log_wr % 256] = mem_addr;
                log_wr = log_wr + 1;
                mem_ack = 1'b1;
            end else if (!mem_req && mem_ack) begin
                repeat ($urandom_range(0, 3)) @(posedge clk);
                #1;
                mem_ack   = 1'b0;
                mem_rdata = 16'($urandom);
            end
        end
    end

    initial begin
        logic req_q;
        req_q     = 1'b0;
        mon_viol  = 0;
        mem_rises = 0;
        forever begin
            @(negedge clk);
            if (rst_n && ack0 && ack1)
                mon_viol = mon_viol + 1;
            if (mem_req && !req_q)
                mem_rises = mem_rises + 1;
            req_q = mem_req;
        end
    end

    task automatic model_reset();
        exp_rdata[0] = 16'h0;
        exp_rdata[1] = 16'h0;
        last_served  = 1;
        exp_err      = 1'b0;
    endtask

    task automatic apply_reset();
        rst_n    = 1'b0;
        rq0      = C_NULL;
        rq1      = C_NULL;
        mem_auto = 1'b1;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        @(negedge clk);
    endtask

    // Raise both commands together from idle, service acks as a requester would,
    // and compare service order, data, memory traffic and err against the model.
    task automatic run_round(input logic [1:0] c0, input logic [15:0] a0,
                             input logic [1:0] c1, input logic [15:0] a1,
                             input string tag);
        logic [1:0]  cmd [2];
        logic [15:0] ad  [2];
        int          st  [2];
        int          exp_order [$];
        int          got_order [$];
        int          rises0, viol0, reads, budget, spur, first;
        logic        p [2];
        logic [15:0] e, rd, rd_other, la;
        cmd[0] = c0; cmd[1] = c1; ad[0] = a0; ad[1] = a1;
        reads = 0;
        spur  = 0;
        for (int i = 0; i < 2; i++) begin
            p[i]  = (cmd[i] == C_READ) || (cmd[i] == C_NOP);
            st[i] = p[i] ? 1 : 0;
            if (cmd[i] == C_READ) reads++;
            if (cmd[i] == C_ILL) exp_err = 1'b1;
        end
        if (p[0] && p[1]) begin
            first = (last_served == 1) ? 0 : 1;
            exp_order.push_back(first);
            exp_order.push_back(1 - first);
        end else if (p[0]) exp_order.push_back(0);
        else if (p[1]) exp_order.push_back(1);
        rises0 = mem_rises;
        viol0  = mon_viol;

        @(negedge clk);
        rq0 = c0; addr0 = a0; rq1 = c1; addr1 = a1;
        budget = 0;
        while ((st[0] == 1 || st[0] == 2 || st[1] == 1 || st[1] == 2 || budget < 8)
               && budget < 400) begin
            @(negedge clk);
            budget++;
            for (int i = 0; i < 2; i++) begin
                logic a;
                a        = (i == 0) ? ack0 : ack1;
                rd       = (i == 0) ? rdata0 : rdata1;
                rd_other = (i == 0) ? rdata1 : rdata0;
                if (st[i] == 1 && a) begin
                    got_order.push_back(i);
                    e = (cmd[i] == C_READ) ? memval(ad[i]) : exp_rdata[i];
                    exp_rdata[i] = e;
                    n_cmp++;
                    if (rd !== e)
                        $display("FAIL %s rdata%0d: got %h expected %h", tag, i, rd, e);
                    if (rd !== e) n_fail++;
                    n_cmp++;
                    if (rd_other !== exp_rdata[1-i]) begin
                        $display("FAIL %s rdata%0d hold: got %h expected %h", tag, 1-i, rd_other, exp_rdata[1-i]);
                        n_fail++;
                    end
                    if (cmd[i] == C_READ) begin
                        n_cmp++;
                        la = log_addr[log_rd % 256];
                        if (log_rd >= log_wr || la !== ad[i]) begin
                            $display("FAIL %s mem_addr%0d: got %h expected %h (logged %0d)", tag, i, la, ad[i], log_wr - log_rd);
                            n_fail++;
                        end
                        if (log_rd < log_wr) log_rd++;
                    end
                    last_served = i;
                    if (i == 0) begin rq0 = C_NULL; addr0 = 16'($urandom); end
                    else        begin rq1 = C_NULL; addr1 = 16'($urandom); end
                    st[i] = 2;
                end else if (st[i] == 2 && !a) begin
                    st[i] = 3;
                end else if (st[i] == 0 && a) begin
                    spur++;
                end
            end
        end
        n_cmp++;
        if (budget >= 400) begin
            $display("FAIL %s timeout: states %0d/%0d expected done", tag, st[0], st[1]);
            n_fail++;
        end
        n_cmp++;
        if (got_order != exp_order) begin
            $display("FAIL %s order: got %p expected %p", tag, got_order, exp_order);
            n_fail++;
        end
        n_cmp++;
        if (mem_rises - rises0 != reads) begin
            $display("FAIL %s mem_req count: got %0d expected %0d", tag, mem_rises - rises0, reads);
            n_fail++;
        end
        n_cmp++;
        if (mon_viol != viol0 || spur != 0) begin
            $display("FAIL %s ack exclusivity: got %0d overlaps %0d stray acks expected 0", tag, mon_viol - viol0, spur);
            n_fail++;
        end
        n_cmp++;
        if (err !== exp_err) begin
            $display("FAIL %s err: got %b expected %b", tag, err, exp_err);
            n_fail++;
        end
        rq0 = C_NULL;
        rq1 = C_NULL;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_reset();
        apply_reset();
        repeat (4) @(negedge clk);
        n_cmp++;
        if ({mem_req, ack0, ack1, err} !== 4'b0 || mem_addr !== 16'h0 ||
            rdata0 !== 16'h0 || rdata1 !== 16'h0) begin
            $display("FAIL reset: got req=%b ack=%b%b err=%b addr=%h rd=%h/%h expected all 0",
                     mem_req, ack0, ack1, err, mem_addr, rdata0, rdata1);
            n_fail++;
        end
    endtask

    task automatic test_single_read();
        run_round(C_READ, 16'h1234, C_NULL, 16'h0, "single_read");
        n_cmp++;
        if (rdata0 !== 16'hBEEF) begin
            $display("FAIL single_read final rdata0: got %h expected beef", rdata0);
            n_fail++;
        end
    endtask

    task automatic test_tie();
        apply_reset();
        run_round(C_READ, 16'h0A0A, C_READ, 16'hB0B0, "tie");
    endtask

    task automatic test_fairness();
        run_round(C_READ, 16'h1111, C_NULL, 16'h0, "fair_solo0");
        run_round(C_READ, 16'h2222, C_READ, 16'h3333, "fair_both");
        run_round(C_NOP, 16'h0, C_NOP, 16'h0, "fair_nop_both");
    endtask

    task automatic test_nop();
        run_round(C_NULL, 16'h0, C_NOP, 16'h4444, "nop1");
    endtask

    task automatic test_illegal();
        run_round(C_ILL, 16'h5555, C_NULL, 16'h0, "illegal0");
        run_round(C_NULL, 16'h0, C_READ, 16'h6666, "after_illegal");
    endtask

    task automatic test_random();
        for (int r = 0; r < 40; r++) begin
            logic [1:0] c [2];
            for (int i = 0; i < 2; i++) begin
                int k;
                k = $urandom_range(0, 9);
                c[i] = (k < 2) ? C_NULL : (k < 7) ? C_READ : (k < 9) ? C_NOP : C_ILL;
            end
            run_round(c[0], 16'($urandom), c[1], 16'($urandom), "random");
        end
    endtask

    task automatic test_reset_mid_txn();
        int w;
        mem_force_ack = 1'b0;
        @(negedge clk);
        mem_auto = 1'b0;
        @(negedge clk);
        rq0 = C_READ; addr0 = 16'h0F0F;
        w = 0;
        while (!mem_req && w < 20) begin @(negedge clk); w++; end
        n_cmp++;
        if (mem_req !== 1'b1 || mem_addr !== 16'h0F0F) begin
            $display("FAIL mid_txn setup: got req=%b addr=%h expected 1/0f0f", mem_req, mem_addr);
            n_fail++;
        end
        mem_force_ack = 1'b1;
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({mem_req, ack0, ack1, err} !== 4'b0 || mem_addr !== 16'h0 ||
            rdata0 !== 16'h0 || rdata1 !== 16'h0) begin
            $display("FAIL async_reset: got req=%b ack=%b%b err=%b addr=%h rd=%h/%h expected all 0",
                     mem_req, ack0, ack1, err, mem_addr, rdata0, rdata1);
            n_fail++;
        end
        model_reset();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        w = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (mem_req) w++;
        end
        n_cmp++;
        if (w != 0) begin
            $display("FAIL reset_gate: got mem_req high %0d cycles expected 0", w);
            n_fail++;
        end
        mem_force_ack = 1'b0;
        w = 0;
        while (!mem_req && w < 10) begin @(negedge clk); w++; end
        n_cmp++;
        if (mem_req !== 1'b1 || mem_addr !== 16'h0F0F) begin
            $display("FAIL reset_resume: got req=%b addr=%h expected 1/0f0f", mem_req, mem_addr);
            n_fail++;
        end
        mem_auto = 1'b1;
        w = 0;
        while (!ack0 && w < 40) begin @(negedge clk); w++; end
        n_cmp++;
        if (ack0 !== 1'b1 || rdata0 !== memval(16'h0F0F)) begin
            $display("FAIL reset_resume ack0: got ack=%b rdata=%h expected 1/%h", ack0, rdata0, memval(16'h0F0F));
            n_fail++;
        end
        log_rd = log_wr;
        rq0 = C_NULL;
        w = 0;
        while (ack0 && w < 20) begin @(negedge clk); w++; end
        n_cmp++;
        if (ack0 !== 1'b0) begin
            $display("FAIL reset_resume ack0 drop: got %b expected 0", ack0);
            n_fail++;
        end
    endtask

    initial begin
        n_cmp         = 0;
        n_fail        = 0;
        log_rd        = 0;
        mem_auto      = 1'b1;
        mem_force_ack = 1'b0;
        rst_n         = 1'b0;
        rq0           = C_NULL;
        rq1           = C_NULL;
        addr0         = 16'h0;
        addr1         = 16'h0;
        model_reset();

        test_reset();
        test_single_read();
        test_tie();
        test_fairness();
        test_nop();
        test_illegal();
        test_random();
        test_reset_mid_txn();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
